// File: rtl/simon_control.sv
// Simon game control FSM: sequences pattern entry, playback, player repeat and
// game over / win by driving the datapath strobes from its status flags.
module simon_control #(
   parameter int unsigned PLAY_CYCLES = 4,
   parameter int unsigned MAX_ENTRIES = 63
) (
   input  logic clk,
   input  logic reset_n,
   input  logic next,
   input  logic right_guess,
   input  logic i_eq_ns,
   input  logic legal,
   output logic reset,
   output logic rst_i,
   output logic count_i,
   output logic count_ns,
   output logic m1,
   output logic m2,
   output logic m3,
   output logic m4,
   output logic win
);

   localparam logic [2:0] S_INIT     = 3'd0;
   localparam logic [2:0] S_INPUT    = 3'd1;
   localparam logic [2:0] S_PLAYBACK = 3'd2;
   localparam logic [2:0] S_REPEAT   = 3'd3;
   localparam logic [2:0] S_RCHK     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_WIN      = 3'd6;

   localparam logic [7:0] LP_LAST = 8'(PLAY_CYCLES - 1);
   localparam logic [5:0] LP_MAX  = 6'(MAX_ENTRIES);

   logic [2:0] r_state;
   logic [7:0] r_timer;
   logic [5:0] r_entries;
   logic       r_next_q;

   logic       w_press;
   logic [2:0] w_state_nxt;
   logic [7:0] w_timer_nxt;
   logic [5:0] w_entries_nxt;

   assign w_press = next & ~r_next_q;

   always_comb begin
      reset         = ~reset_n;
      rst_i         = 1'b0;
      count_i       = 1'b0;
      count_ns      = 1'b0;
      m1            = 1'b0;
      m2            = 1'b0;
      m3            = 1'b0;
      m4            = 1'b0;
      win           = 1'b0;
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_entries_nxt = r_entries;

      case (r_state)
         S_INIT: begin
            reset         = 1'b1;
            w_timer_nxt   = '0;
            w_entries_nxt = '0;
            w_state_nxt   = S_INPUT;
         end

         S_INPUT: begin
            m1 = 1'b1;
            if (w_press && legal) begin
               count_ns    = 1'b1;
               rst_i       = 1'b1;
               w_timer_nxt = '0;
               if (r_entries < LP_MAX) begin
                  w_entries_nxt = r_entries + 6'd1;
               end
               w_state_nxt = S_PLAYBACK;
            end
         end

         S_PLAYBACK: begin
            m2 = 1'b1;
            // Exit is tested before display so no cycle is spent on index ns.
            if (i_eq_ns) begin
               rst_i       = 1'b1;
               w_timer_nxt = '0;
               w_state_nxt = S_REPEAT;
            end else if (r_timer >= LP_LAST) begin
               count_i     = 1'b1;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 8'd1;
            end
         end

         S_REPEAT: begin
            m3 = 1'b1;
            if (w_press && legal) begin
               if (right_guess) begin
                  count_i     = 1'b1;
                  w_state_nxt = S_RCHK;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end

         S_RCHK: begin
            m3 = 1'b1;
            if (!i_eq_ns) begin
               w_state_nxt = S_REPEAT;
            end else if (r_entries == LP_MAX) begin
               w_state_nxt = S_WIN;
            end else begin
               rst_i       = 1'b1;
               w_state_nxt = S_INPUT;
            end
         end

         S_DONE: begin
            m4 = 1'b1;
            if (w_press) begin
               w_state_nxt = S_INIT;
            end
         end

         S_WIN: begin
            m4  = 1'b1;
            win = 1'b1;
            if (w_press) begin
               w_state_nxt = S_INIT;
            end
         end

         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_INIT;
         r_timer   <= '0;
         r_entries <= '0;
         r_next_q  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_entries <= w_entries_nxt;
         r_next_q  <= next;
      end
   end

endmodule

// File: tb/tb_simon_control.sv
// Bench for simon_control: game scripts are expanded into per-cycle
// {inputs, expected outputs} records from the game rules, then replayed.
module tb_simon_control;

   localparam logic [8:0] O_RESET = 9'b1_0000_0000;
   localparam logic [8:0] O_RSTI  = 9'b0_1000_0000;
   localparam logic [8:0] O_CNTI  = 9'b0_0100_0000;
   localparam logic [8:0] O_CNTNS = 9'b0_0010_0000;
   localparam logic [8:0] O_M1    = 9'b0_0001_0000;
   localparam logic [8:0] O_M2    = 9'b0_0000_1000;
   localparam logic [8:0] O_M3    = 9'b0_0000_0100;
   localparam logic [8:0] O_M4    = 9'b0_0000_0010;
   localparam logic [8:0] O_WIN   = 9'b0_0000_0001;
   localparam logic [8:0] ALL     = 9'h1FF;

   typedef struct {
      bit         rst_n;
      bit         nx;
      bit         rg;
      bit         ieq;
      bit         lg;
      logic [8:0] exp;
      logic [8:0] mask;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst_n, a_next, a_rg, a_ieq, a_lg;
   logic a_reset, a_rst_i, a_count_i, a_count_ns, a_m1, a_m2, a_m3, a_m4, a_win;
   logic b_rst_n, b_next, b_rg, b_ieq, b_lg;
   logic b_reset, b_rst_i, b_count_i, b_count_ns, b_m1, b_m2, b_m3, b_m4, b_win;

   simon_control #(.PLAY_CYCLES(4), .MAX_ENTRIES(63)) dut_a (
      .clk(clk), .reset_n(a_rst_n), .next(a_next), .right_guess(a_rg),
      .i_eq_ns(a_ieq), .legal(a_lg), .reset(a_reset), .rst_i(a_rst_i),
      .count_i(a_count_i), .count_ns(a_count_ns), .m1(a_m1), .m2(a_m2),
      .m3(a_m3), .m4(a_m4), .win(a_win)
   );

   simon_control #(.PLAY_CYCLES(1), .MAX_ENTRIES(2)) dut_b (
      .clk(clk), .reset_n(b_rst_n), .next(b_next), .right_guess(b_rg),
      .i_eq_ns(b_ieq), .legal(b_lg), .reset(b_reset), .rst_i(b_rst_i),
      .count_i(b_count_i), .count_ns(b_count_ns), .m1(b_m1), .m2(b_m2),
      .m3(b_m3), .m4(b_m4), .win(b_win)
   );

   wire [8:0] a_out = {a_reset, a_rst_i, a_count_i, a_count_ns, a_m1, a_m2, a_m3, a_m4, a_win};
   wire [8:0] b_out = {b_reset, b_rst_i, b_count_i, b_count_ns, b_m1, b_m2, b_m3, b_m4, b_win};

   vec_t tr[$];
   bit   prev_next;
   int   checks = 0;
   int   errors = 0;

   function automatic bit rb();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic add(input bit rst_n, input bit nx, input bit rg, input bit ieq,
                      input bit lg, input logic [8:0] e, input logic [8:0] m);
      vec_t v;
      v.rst_n = rst_n; v.nx = nx; v.rg = rg; v.ieq = ieq; v.lg = lg;
      v.exp = e; v.mask = m;
      tr.push_back(v);
      prev_next = nx;
   endtask

   // A press needs a low level first; a release cycle is inserted when needed.
   task automatic press(input bit rg, input bit lg, input logic [8:0] e_press,
                        input logic [8:0] e_idle);
      if (prev_next) add(1, 0, rb(), rb(), rb(), e_idle, ALL);
      add(1, 1, rg, rb(), lg, e_press, ALL);
   endtask

   task automatic power_reset(input int n, input bit hold);
      for (int k = 0; k < n; k++)
         add(0, hold, rb(), rb(), rb(), O_RESET, (k == 0) ? O_RESET : ALL);
      add(1, hold, rb(), rb(), rb(), O_RESET, ALL);
   endtask

   task automatic input_round(input int idle, input int illegal);
      for (int k = 0; k < idle; k++) add(1, 0, rb(), rb(), rb(), O_M1, ALL);
      for (int k = 0; k < illegal; k++) press(rb(), 0, O_M1, O_M1);
      press(rb(), 1, O_M1 | O_RSTI | O_CNTNS, O_M1);
   endtask

   // Round r shows r entries for pc cycles each, then one exit cycle.
   task automatic playback(input int r, input int pc, input int stop_at);
      for (int c = 0; c < r * pc; c++) begin
         logic [8:0] e;
         e = O_M2 | (((c % pc) == pc - 1) ? O_CNTI : 9'h000);
         if (c == stop_at) begin
            add(0, rb(), rb(), 0, rb(), e | O_RESET, ALL);
            return;
         end
         add(1, rb(), rb(), 0, rb(), e, ALL);
      end
      add(1, rb(), rb(), 1, rb(), O_M2 | O_RSTI, ALL);
   endtask

   task automatic repeat_phase(input int r, input int fail_at, input int maxe,
                               output bit lost, output bit won);
      lost = 0;
      won  = 0;
      for (int g = 0; g < r; g++) begin
         bit last;
         for (int k = 0; k < int'($urandom_range(2, 0)); k++)
            add(1, 0, rb(), rb(), rb(), O_M3, ALL);
         if (rb()) press(rb(), 0, O_M3, O_M3);
         if (g == fail_at) begin
            press(0, 1, O_M3, O_M3);
            lost = 1;
            return;
         end
         press(1, 1, O_M3 | O_CNTI, O_M3);
         last = (g == r - 1);
         add(1, rb(), rb(), last, rb(), O_M3 | ((last && r != maxe) ? O_RSTI : 9'h000), ALL);
         if (last && r == maxe) won = 1;
      end
   endtask

   task automatic end_phase(input bit w);
      logic [8:0] e;
      e = O_M4 | (w ? O_WIN : 9'h000);
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) add(1, 0, rb(), rb(), rb(), e, ALL);
      press(rb(), rb(), e, e);
      add(1, 0, rb(), rb(), rb(), O_RESET, ALL);
   endtask

   task automatic play_game(input int pc, input int maxe, input int max_rounds, input bit may_fail);
      for (int r = 1; r <= maxe; r++) begin
         int fail_at;
         bit lost, won;
         input_round(int'($urandom_range(2, 0)), int'($urandom_range(1, 0)));
         playback(r, pc, -1);
         fail_at = -1;
         if (r == max_rounds && r != maxe) fail_at = int'($urandom_range(r - 1, 0));
         else if (may_fail && ($urandom_range(3, 0) == 0)) fail_at = int'($urandom_range(r - 1, 0));
         repeat_phase(r, fail_at, maxe, lost, won);
         if (lost || won) begin
            end_phase(won);
            return;
         end
      end
   endtask

   task automatic run_trace(input int sel);
      foreach (tr[k]) begin
         logic [8:0] got;
         @(posedge clk);
         #1;
         if (sel == 0) begin
            a_rst_n = tr[k].rst_n; a_next = tr[k].nx; a_rg = tr[k].rg;
            a_ieq = tr[k].ieq; a_lg = tr[k].lg;
         end else begin
            b_rst_n = tr[k].rst_n; b_next = tr[k].nx; b_rg = tr[k].rg;
            b_ieq = tr[k].ieq; b_lg = tr[k].lg;
         end
         @(negedge clk);
         got = (sel == 0) ? a_out : b_out;
         checks++;
         if ((got & tr[k].mask) !== (tr[k].exp & tr[k].mask)) begin
            errors++;
            $display("FAIL inst%0d vec%0d outputs{reset,rst_i,count_i,count_ns,m1..m4,win}: got=%b want=%b mask=%b",
                     sel, k, got, tr[k].exp, tr[k].mask);
         end
      end
      tr.delete();
   endtask

   initial begin
      bit lost, won;
      a_rst_n = 0; a_next = 0; a_rg = 0; a_ieq = 0; a_lg = 0;
      b_rst_n = 0; b_next = 0; b_rg = 0; b_ieq = 0; b_lg = 0;
      prev_next = 0;

      // Instance A: PLAY_CYCLES=4, MAX_ENTRIES=63.
      power_reset(3, 0);
      input_round(1, 1);
      playback(1, 4, -1);
      repeat_phase(1, -1, 63, lost, won);
      input_round(0, 0);
      playback(2, 4, -1);
      repeat_phase(2, -1, 63, lost, won);
      input_round(0, 0);
      playback(3, 4, -1);
      repeat_phase(3, 1, 63, lost, won);
      end_phase(0);
      for (int n = 0; n < 6; n++) play_game(4, 63, int'($urandom_range(5, 1)), 1);
      run_trace(0);

      // Instance B: PLAY_CYCLES=1, MAX_ENTRIES=2; next held high through reset.
      prev_next = 0;
      power_reset(2, 1);
      add(1, 1, rb(), rb(), 1, O_M1, ALL);
      add(1, 1, rb(), rb(), 1, O_M1, ALL);
      play_game(1, 2, 2, 0);
      input_round(0, 0);
      playback(1, 1, -1);
      repeat_phase(1, -1, 2, lost, won);
      input_round(0, 0);
      playback(2, 1, 1);
      add(1, 0, rb(), rb(), rb(), O_RESET, ALL);
      play_game(1, 2, 2, 0);
      for (int n = 0; n < 6; n++) play_game(1, 2, int'($urandom_range(2, 1)), 1);
      run_trace(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/simon_control.md
# simon_control

Control FSM for the Simon game. It sequences the Simon datapath through four phases: pattern entry, playback, player repeat, and game over / win. It drives the datapath's control strobes (`count_ns`, `rst_i`, `count_i`, `m1`..`m4`, datapath `reset`) from the datapath status flags and the player's "next" button. It sits between the board I/O and the datapath, one instance per game.

## Interface
Parameters:
- `PLAY_CYCLES`, default 4: cycles each stored entry is displayed during playback; legal range 1..255.
- `MAX_ENTRIES`, default 63: entries per game before win; legal range 1..63. This limit keeps the datapath's 6-bit `ns` from wrapping.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `next` input 1: player button level, already synchronous to `clk`.
- `right_guess` input 1: datapath flag; current guess matches the stored entry at `i`.
- `i_eq_ns` input 1: datapath flag; `i == ns`.
- `legal` input 1: datapath flag; switch pattern is legal for the current level.
- `reset` output 1: datapath global reset.
- `rst_i` output 1: clear datapath `i`.
- `count_i` output 1: increment datapath `i`.
- `count_ns` output 1: increment datapath `ns`.
- `m1` output 1: INPUT phase; also acts as the memory write enable.
- `m2` output 1: PLAYBACK phase.
- `m3` output 1: REPEAT phase.
- `m4` output 1: DONE or WIN phase.
- `win` output 1: high only in WIN.

## Operation
Registered state:
- `state`
- `timer`: 8 bits.
- `entries`: 6 bits, the number of stored entries.
- `next_q`: previous value of `next`.

Button edge detect: `press = next & ~next_q`. Presses arriving in a state that does not use them are discarded.

All outputs are combinational decodes of `state` and the inputs. Every strobe not listed for a state is 0.

States and transitions:
- **INIT**
  - Outputs: `reset`=1.
  - Next state: INPUT, unconditionally.
- **INPUT**
  - Outputs: `m1`=1. The datapath writes `pattern` to `mem[ns]` every cycle.
  - `press & legal`: `count_ns`=1, `rst_i`=1, `entries`+1, go to PLAYBACK.
  - `press & ~legal`: ignored; stay in INPUT.
- **PLAYBACK**
  - Outputs: `m2`=1.
  - If `i_eq_ns`: `rst_i`=1, `timer`←0, go to REPEAT. This is checked before display, so zero cycles are spent on index `ns`.
  - Otherwise: `timer`+1 each cycle. When `timer == PLAY_CYCLES-1`: `count_i`=1, `timer`←0.
- **REPEAT**
  - Outputs: `m3`=1.
  - `press & ~legal`: ignored.
  - `press & legal & ~right_guess`: go to DONE. `i` is held at the failing index.
  - `press & legal & right_guess`: `count_i`=1, go to RCHK.
- **RCHK** (one cycle)
  - Outputs: `m3`=1.
  - If `~i_eq_ns`: return to REPEAT.
  - Else if `entries == MAX_ENTRIES`: go to WIN.
  - Else: `rst_i`=1, go to INPUT for the next round.
- **DONE**
  - Outputs: `m4`=1. The datapath displays the correct entry at the failing `i`.
  - `press`: go to INIT (new game).
- **WIN**
  - Outputs: `m4`=1, `win`=1.
  - `press`: go to INIT.

Reset behaviour:
- `reset_n`=0 at an edge sets `state`←INIT, `timer`←0, `entries`←0, `next_q`←0.
- While `reset_n`=0, `reset` is forced to 1 combinationally, and every other output is decoded from the current state.
- A reset mid-game always lands in INIT and then INPUT. There are no partial-state carryovers.

Boundary conditions:
- INIT clears `entries`.
- `entries` never exceeds `MAX_ENTRIES`.
- A `next` held high through reset does not produce a press in INPUT unless it is released and pressed again. Its edge, if any, is consumed in INIT.
- `PLAY_CYCLES`=1: one display cycle per entry, `count_i` every PLAYBACK cycle.

## Timing
- Press to state change: 1 cycle. The strobe is asserted in the same cycle as `press`.
- Playback duration for round N: `N*PLAY_CYCLES + 1` cycles, where the final cycle is the `i_eq_ns` exit.
- Each correct guess costs 2 cycles: REPEAT with `count_i`, then RCHK.
- After reset release: 1 cycle in INIT, then INPUT.

## Test plan
1. Reset sequencing:
   - Stimulus: hold `reset_n`=0 for 3 cycles, then release.
   - Response: `reset`=1 throughout and for exactly 1 cycle after release; `m1`=1 on the next cycle; all other strobes 0.
2. Legal check in INPUT:
   - Stimulus: in INPUT, press with `legal`=0, then press with `legal`=1.
   - Response: the first press produces no strobe; the second produces a single cycle with `count_ns`=1 and `rst_i`=1, then `m2`=1.
3. Playback timing:
   - Stimulus: behavioral datapath model, `PLAY_CYCLES`=4, round 3.
   - Response: `count_i` pulses exactly every 4 cycles, 3 times, then `rst_i` with the transition to REPEAT; total 13 PLAYBACK cycles.
4. Correct repeat:
   - Stimulus: in round 2, two legal correct presses.
   - Response: REPEAT→RCHK→REPEAT→RCHK, with `rst_i`=1 on the final RCHK, then `m1`=1.
5. Wrong guess:
   - Stimulus: `right_guess`=0 on a legal press in REPEAT.
   - Response: `m4`=1, `win`=0, `count_i`=0 in that cycle; a later press returns to INIT with `reset`=1.
6. Win and mid-game reset:
   - Stimulus: `MAX_ENTRIES`=2; complete round 2 correctly.
   - Response: WIN with `win`=1 and `m4`=1.
   - Stimulus: pulse `reset_n` low during PLAYBACK.
   - Response: INIT, `entries`=0.
